// File: rtl/div_share_arb_if.sv
// ----------------------------------------------------------------------------
// div_share_arb_if
//   Bundle between NREQ requesters, the shared-divider arbiter and the single
//   divider core.
//
//   Requester side : req_valid / req_a / req_b        (requester -> arbiter)
//                    req_ready / resp_valid / resp_data / resp_err
//                                                     (arbiter -> requester)
//   Divider side   : div_init / div_a / div_b         (arbiter -> divider)
//                    div_result / div_busy            (divider -> arbiter)
//   Status         : arb_busy                         (arbiter -> anyone)
//
//   slave  : the arbiter's view
//   master : the environment's view (requesters plus divider)
// ----------------------------------------------------------------------------
interface div_share_arb_if #(
    parameter int NREQ = 2,
    parameter int W    = 64
);
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*W-1:0] req_a;
    logic [NREQ*W-1:0] req_b;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ-1:0]   resp_valid;
    logic [W-1:0]      resp_data;
    logic              resp_err;
    logic              div_init;
    logic [W-1:0]      div_a;
    logic [W-1:0]      div_b;
    logic [W-1:0]      div_result;
    logic              div_busy;
    logic              arb_busy;

    modport slave (
        input  req_valid, req_a, req_b, div_result, div_busy,
        output req_ready, resp_valid, resp_data, resp_err,
               div_init, div_a, div_b, arb_busy
    );

    modport master (
        output req_valid, req_a, req_b, div_result, div_busy,
        input  req_ready, resp_valid, resp_data, resp_err,
               div_init, div_a, div_b, arb_busy
    );
endinterface

// File: rtl/div_share_arb.sv
// ----------------------------------------------------------------------------
// div_share_arb
//   Round-robin arbiter and sequencer that shares one divider core between
//   NREQ requesters. Each transaction latches one request's operands, pulses
//   the divider start for INIT_CYC cycles, follows the divider's busy rise
//   and fall, and hands the quotient back to the owner as a one-cycle
//   response. A zero divisor is answered locally and never reaches the core.
//
// Ports
//   clk          in   rising-edge clock
//   rst          in   synchronous reset, active-high
//   bus          slave modport of div_share_arb_if (requests, responses,
//                divider handshake, arb_busy)
//   o_dbg_state  out  current FSM state (state_t encoding)
//
// Handshake semantics
//   A requester raises req_valid[i] with its operands and holds both until it
//   sees req_ready[i]. req_ready is a one-hot pulse during the IDLE cycle in
//   which the request wins arbitration; the operands are captured on the
//   clock edge that ends that cycle, so valid & ready in a cycle means the
//   transfer happens at the following edge. The result comes back later as a
//   one-cycle resp_valid[i] pulse; there is no backpressure on responses.
// ----------------------------------------------------------------------------
module div_share_arb #(
    parameter int NREQ     = 2,
    parameter int W        = 64,
    parameter int INIT_CYC = 4,
    parameter int BUSY_TO  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    div_share_arb_if.slave       bus,
    output logic [2:0]           o_dbg_state
);
    localparam int PW   = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CMAX = (INIT_CYC > BUSY_TO) ? INIT_CYC : BUSY_TO;
    localparam int CW   = $clog2(CMAX + 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_WAIT_RISE = 3'd2,
        S_WAIT_FALL = 3'd3,
        S_RESP      = 3'd4
    } state_t;

    state_t          r_state;
    logic [PW-1:0]   r_rr_ptr;
    logic [PW-1:0]   r_owner;
    logic [CW-1:0]   r_cnt;
    logic            r_div_init;
    logic [W-1:0]    r_div_a;
    logic [W-1:0]    r_div_b;
    logic [NREQ-1:0] r_resp_valid;
    logic [W-1:0]    r_resp_data;
    logic            r_resp_err;

    logic            w_gnt_vld;
    logic [PW-1:0]   w_gnt_idx;
    logic [NREQ-1:0] w_gnt_oh;
    logic [NREQ-1:0] w_own_oh;
    logic [PW-1:0]   w_rr_next;
    logic [W-1:0]    w_sel_a;
    logic [W-1:0]    w_sel_b;

    // First requester at or after r_rr_ptr, scanning with wrap-around.
    always_comb begin
        int v_idx;
        v_idx     = 0;
        w_gnt_vld = 1'b0;
        w_gnt_idx = '0;
        for (int k = 0; k < NREQ; k++) begin
            v_idx = int'(r_rr_ptr) + k;
            if (v_idx >= NREQ) begin
                v_idx = v_idx - NREQ;
            end
            if (!w_gnt_vld && bus.req_valid[v_idx[PW-1:0]]) begin
                w_gnt_vld = 1'b1;
                w_gnt_idx = v_idx[PW-1:0];
            end
        end
    end

    assign w_gnt_oh  = w_gnt_vld ? (NREQ'(1) << w_gnt_idx) : '0;
    assign w_own_oh  = NREQ'(1) << r_owner;
    assign w_rr_next = (w_gnt_idx == PW'(NREQ - 1)) ? '0 : w_gnt_idx + PW'(1);
    assign w_sel_a   = bus.req_a[int'(w_gnt_idx)*W +: W];
    assign w_sel_b   = bus.req_b[int'(w_gnt_idx)*W +: W];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_rr_ptr     <= '0;
            r_owner      <= '0;
            r_cnt        <= '0;
            r_div_init   <= 1'b0;
            r_div_a      <= '0;
            r_div_b      <= '0;
            r_resp_valid <= '0;
            r_resp_data  <= '0;
            r_resp_err   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_resp_valid <= '0;
                    r_resp_data  <= '0;
                    r_resp_err   <= 1'b0;
                    if (w_gnt_vld) begin
                        r_div_a  <= w_sel_a;
                        r_div_b  <= w_sel_b;
                        r_owner  <= w_gnt_idx;
                        r_rr_ptr <= w_rr_next;
                        if (w_sel_b == '0) begin
                            // Zero divisor: answer straight away, core untouched.
                            r_state      <= S_RESP;
                            r_resp_valid <= w_gnt_oh;
                            r_resp_data  <= '1;
                            r_resp_err   <= 1'b1;
                        end else begin
                            r_state    <= S_START;
                            r_div_init <= 1'b1;
                            r_cnt      <= '0;
                        end
                    end
                end
                S_START: begin
                    if (r_cnt == CW'(INIT_CYC - 1)) begin
                        r_div_init <= 1'b0;
                        r_cnt      <= '0;
                        r_state    <= S_WAIT_RISE;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_WAIT_RISE: begin
                    if (bus.div_busy) begin
                        r_state <= S_WAIT_FALL;
                    end else if (r_cnt == CW'(BUSY_TO - 1)) begin
                        // Divider never acknowledged the start.
                        r_state      <= S_RESP;
                        r_resp_valid <= w_own_oh;
                        r_resp_data  <= '0;
                        r_resp_err   <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_WAIT_FALL: begin
                    if (!bus.div_busy) begin
                        r_state      <= S_RESP;
                        r_resp_valid <= w_own_oh;
                        r_resp_data  <= bus.div_result;
                        r_resp_err   <= 1'b0;
                    end
                end
                S_RESP: begin
                    r_resp_valid <= '0;
                    r_resp_data  <= '0;
                    r_resp_err   <= 1'b0;
                    r_state      <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Ready is only offered from IDLE and never while reset is held.
    assign bus.req_ready  = (r_state == S_IDLE && !rst) ? w_gnt_oh : '0;
    assign bus.resp_valid = r_resp_valid;
    assign bus.resp_data  = r_resp_data;
    assign bus.resp_err   = r_resp_err;
    assign bus.div_init   = r_div_init;
    assign bus.div_a      = r_div_a;
    assign bus.div_b      = r_div_b;
    assign bus.arb_busy   = (r_state != S_IDLE);
    assign o_dbg_state    = r_state;
endmodule

// File: tb/tb_div_share_arb.sv
module tb_div_share_arb;
  logic       clk;
  logic       rst;
  logic [2:0] dbg_state;

  div_share_arb_if #(.NREQ(2), .W(64)) bus();

  div_share_arb #(
    .NREQ(2), .W(64), .INIT_CYC(4), .BUSY_TO(16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- divider model ----------------
  // After div_init falls it waits m_rise_d cycles, raises busy for m_div_d
  // cycles, then drops busy with the quotient on div_result.
  // With the default settings (2, 5) the response arrives 13 cycles after
  // the accept cycle: 1 accept + 4 init + 3 rise + 5 divide.
  int         m_rise_d = 2;
  int         m_div_d  = 5;
  bit         m_en     = 1'b1;
  int         m_phase;
  int         m_cnt;

  initial begin
    bus.div_busy   = 1'b0;
    bus.div_result = '0;
    m_phase        = 0;
    m_cnt          = 0;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        m_phase      = 0;
        bus.div_busy = 1'b0;
      end else begin
        if (m_phase == 0) begin
          if (bus.div_init) m_phase = 1;
        end
        if (m_phase == 1 && !bus.div_init) begin
          m_phase = m_en ? 2 : 0;
          m_cnt   = m_rise_d;
        end
        if (m_phase == 2) begin
          if (m_cnt == 0) begin
            bus.div_busy = 1'b1;
            m_cnt        = m_div_d;
            m_phase      = 3;
          end else begin
            m_cnt = m_cnt - 1;
          end
        end else if (m_phase == 3) begin
          m_cnt = m_cnt - 1;
          if (m_cnt == 0) begin
            bus.div_busy   = 1'b0;
            bus.div_result = (bus.div_b != 0) ? bus.div_a / bus.div_b : '0;
            m_phase        = 0;
          end
        end
      end
    end
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic apply_reset();
    rst           = 1'b1;
    bus.req_valid = '0;
    repeat (2) @(negedge clk);
  endtask

  task automatic set_req(input logic [1:0] vld, input logic [63:0] a0, input logic [63:0] b0,
                         input logic [63:0] a1, input logic [63:0] b1);
    bus.req_a     = {a1, a0};
    bus.req_b     = {b1, b0};
    bus.req_valid = vld;
  endtask

  // Returns at negedge+1 of the cycle in which a grant is offered.
  task automatic wait_ready(output logic [1:0] g);
    g = '0;
    for (int n = 0; n < 40; n++) begin
      #1;
      if (bus.req_ready != 2'b00) begin
        g = bus.req_ready;
        return;
      end
      @(negedge clk);
    end
    checks++;
    errors++;
    $display("FAIL wait_ready actual=no_grant required=grant");
  endtask

  // Counts cycles from the accept cycle until resp_valid; returns at that negedge.
  task automatic wait_resp(input logic [1:0] drop, output int lat, output int inits);
    lat   = 0;
    inits = 0;
    for (int n = 0; n < 64; n++) begin
      @(negedge clk);
      lat++;
      if (bus.div_init) inits++;
      if (bus.resp_valid != 2'b00) return;
      if (lat == 1) bus.req_valid = bus.req_valid & ~drop;
    end
    checks++;
    errors++;
    $display("FAIL wait_resp actual=no_response required=response");
  endtask

  task automatic chk_idle(input string name);
    @(negedge clk);
    chk({name, "_resp_valid"}, {62'd0, bus.resp_valid}, 64'd0);
    chk({name, "_resp_data"}, bus.resp_data, 64'd0);
    chk({name, "_arb_busy"}, {63'd0, bus.arb_busy}, 64'd0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [1:0]  vld;
    logic [63:0] a0, b0, a1, b1;
    logic [1:0]  exp_gnt;
    logic [63:0] exp_data;
    logic        exp_err;
    int          exp_lat;
    int          exp_inits;
  } vec_t;

  vec_t vecs[7];

  initial begin
    logic [1:0]  g;
    logic [1:0]  rv;
    int          lat;
    int          inits;
    int          cnt;
    logic [63:0] a2;
    logic [63:0] q2;

    rst           = 1'b1;
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;

    vecs[0] = '{2'b01, 64'd8835 << 32, 64'd100000000, 64'd123, 64'd3,
                2'b01, 64'd379460, 1'b0, 13, 4};
    vecs[1] = '{2'b10, 64'd999, 64'd9, 64'd1000, 64'd7,
                2'b10, 64'd142, 1'b0, 13, 4};
    vecs[2] = '{2'b10, 64'd999, 64'd9, 64'd5, 64'd0,
                2'b10, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1, 0};
    vecs[3] = '{2'b01, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd50, 64'd5,
                2'b01, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 13, 4};
    vecs[4] = '{2'b01, 64'd3, 64'd10, 64'd77, 64'd1,
                2'b01, 64'd0, 1'b0, 13, 4};
    vecs[5] = '{2'b01, 64'd0, 64'd0, 64'd40, 64'd2,
                2'b01, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1, 0};
    vecs[6] = '{2'b10, 64'd7, 64'd7, 64'd1_000_000_007, 64'd1000,
                2'b10, 64'd1_000_000, 1'b0, 13, 4};

    // ---- reset state ----
    apply_reset();
    chk("rst_req_ready", {62'd0, bus.req_ready}, 64'd0);
    chk("rst_resp_valid", {62'd0, bus.resp_valid}, 64'd0);
    chk("rst_resp_data", bus.resp_data, 64'd0);
    chk("rst_resp_err", {63'd0, bus.resp_err}, 64'd0);
    chk("rst_div_init", {63'd0, bus.div_init}, 64'd0);
    chk("rst_div_a", bus.div_a, 64'd0);
    chk("rst_div_b", bus.div_b, 64'd0);
    chk("rst_arb_busy", {63'd0, bus.arb_busy}, 64'd0);
    chk("rst_state", {61'd0, dbg_state}, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // ---- table-driven single transactions ----
    for (int i = 0; i < 7; i++) begin
      set_req(vecs[i].vld, vecs[i].a0, vecs[i].b0, vecs[i].a1, vecs[i].b1);
      wait_ready(g);
      chk($sformatf("v%0d_grant", i), {62'd0, g}, {62'd0, vecs[i].exp_gnt});
      exp_q.push_back(vecs[i].exp_data);
      wait_resp(vecs[i].vld, lat, inits);
      rv = bus.resp_valid;
      chk($sformatf("v%0d_resp_valid", i), {62'd0, rv}, {62'd0, vecs[i].exp_gnt});
      chk($sformatf("v%0d_resp_data", i), bus.resp_data, exp_q.pop_front());
      chk($sformatf("v%0d_resp_err", i), {63'd0, bus.resp_err}, {63'd0, vecs[i].exp_err});
      chk($sformatf("v%0d_latency", i), 64'(lat), 64'(vecs[i].exp_lat));
      chk($sformatf("v%0d_init_cycles", i), 64'(inits), 64'(vecs[i].exp_inits));
      chk_idle($sformatf("v%0d_after", i));
    end

    // ---- both requesters in the same cycle from reset ----
    apply_reset();
    rst = 1'b0;
    a2  = 64'd289505280 << 32;
    q2  = a2 / 64'd100000000;
    set_req(2'b11, 64'd8835 << 32, 64'd100000000, a2, 64'd100000000);
    wait_ready(g);
    chk("both_first_grant", {62'd0, g}, 64'd1);
    wait_resp(2'b01, lat, inits);
    chk("both_first_resp_valid", {62'd0, bus.resp_valid}, 64'd1);
    chk("both_first_resp_data", bus.resp_data, 64'd379460);
    @(negedge clk);
    #1;
    chk("both_second_grant_next_idle", {62'd0, bus.req_ready}, 64'd2);
    wait_resp(2'b10, lat, inits);
    chk("both_second_resp_valid", {62'd0, bus.resp_valid}, 64'd2);
    chk("both_second_resp_data", bus.resp_data, q2);
    chk("both_second_latency", 64'(lat), 64'd13);
    chk_idle("both_after");

    // ---- fairness with both held valid ----
    apply_reset();
    rst = 1'b0;
    set_req(2'b11, 64'd100, 64'd7, 64'd1000, 64'd9);
    for (int t = 0; t < 6; t++) begin
      wait_ready(g);
      chk($sformatf("fair%0d_grant", t), {62'd0, g}, (t % 2 == 0) ? 64'd1 : 64'd2);
      wait_resp(2'b00, lat, inits);
      chk($sformatf("fair%0d_resp_valid", t), {62'd0, bus.resp_valid}, (t % 2 == 0) ? 64'd1 : 64'd2);
      chk($sformatf("fair%0d_resp_data", t), bus.resp_data, (t % 2 == 0) ? 64'd14 : 64'd111);
    end
    bus.req_valid = 2'b00;
    chk_idle("fair_after");

    // ---- divider never raises busy ----
    m_en = 1'b0;
    set_req(2'b01, 64'd50, 64'd5, 64'd0, 64'd1);
    wait_ready(g);
    chk("to_grant", {62'd0, g}, 64'd1);
    wait_resp(2'b01, lat, inits);
    chk("to_resp_valid", {62'd0, bus.resp_valid}, 64'd1);
    chk("to_resp_err", {63'd0, bus.resp_err}, 64'd1);
    chk("to_resp_data", bus.resp_data, 64'd0);
    chk("to_latency", 64'(lat), 64'd21);
    chk("to_init_cycles", 64'(inits), 64'd4);
    @(negedge clk);
    chk("to_state_idle", {61'd0, dbg_state}, 64'd0);
    m_en = 1'b1;

    // ---- reset during START drops div_init at once ----
    set_req(2'b01, 64'd90, 64'd9, 64'd0, 64'd1);
    wait_ready(g);
    @(negedge clk);
    bus.req_valid = 2'b00;
    chk("rs_start_init_high", {63'd0, bus.div_init}, 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rs_start_init_low", {63'd0, bus.div_init}, 64'd0);
    chk("rs_start_arb_busy", {63'd0, bus.arb_busy}, 64'd0);

    // ---- reset during WAIT_FALL ----
    m_div_d = 10;
    set_req(2'b01, 64'd77, 64'd7, 64'd0, 64'd1);
    wait_ready(g);
    cnt = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (n == 0) bus.req_valid = 2'b00;
      if (dbg_state == 3'd3) break;
      cnt++;
    end
    chk("rf_reached_wait_fall", {61'd0, dbg_state}, 64'd3);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rf_arb_busy", {63'd0, bus.arb_busy}, 64'd0);
    chk("rf_div_init", {63'd0, bus.div_init}, 64'd0);
    chk("rf_resp_valid", {62'd0, bus.resp_valid}, 64'd0);
    cnt = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (bus.resp_valid != 2'b00) cnt++;
    end
    chk("rf_no_stale_resp", 64'(cnt), 64'd0);
    m_div_d = 5;
    set_req(2'b01, 64'd77, 64'd7, 64'd0, 64'd1);
    wait_ready(g);
    chk("rf_fresh_grant", {62'd0, g}, 64'd1);
    wait_resp(2'b01, lat, inits);
    chk("rf_fresh_resp_valid", {62'd0, bus.resp_valid}, 64'd1);
    chk("rf_fresh_resp_data", bus.resp_data, 64'd11);
    chk("rf_fresh_resp_err", {63'd0, bus.resp_err}, 64'd0);
    chk("rf_fresh_latency", 64'(lat), 64'd13);
    chk_idle("rf_after");

    // ---- final report ----
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
